// File: rtl/sipo_piso_master.sv
// Serial initiator for the SIPO/PISO configuration register slave.
// Converts one parallel write/read request into a strobe-framed serial frame.
module sipo_piso_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  strobe,
    output logic                  wr_en,
    output logic                  sdo,
    input  logic                  sdi
);

    localparam int FRAME = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW    = $clog2(FRAME);
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME - 1);
    localparam logic [CW-1:0] FIRST_DATA = CW'(ADDR_WIDTH);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t                state;
    logic                  is_write;
    logic [FRAME-1:0]      tx;
    logic [DATA_WIDTH-1:0] rx;
    logic [CW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;

    assign req_ready = (state == S_IDLE);

    // Reads zero-extend the address so sdo naturally falls to 0 after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            is_write  <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            strobe    <= 1'b0;
            wr_en     <= 1'b0;
            sdo       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            strobe    <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        state    <= S_SETUP;
                        is_write <= req_write;
                        wr_en    <= req_write;
                        busy     <= 1'b1;
                        sdo      <= 1'b0;
                        tx       <= req_write ? {req_addr, req_wdata} : FRAME'(req_addr);
                    end
                end
                S_SETUP: begin
                    state  <= S_STROBE;
                    strobe <= 1'b1;
                end
                S_STROBE: begin
                    state   <= S_SHIFT;
                    bit_cnt <= '0;
                    sdo     <= tx[0];
                    tx      <= tx >> 1;
                end
                S_SHIFT: begin
                    // Read data arrives LSB first; after DATA_WIDTH samples rx is fully replaced.
                    if (!is_write && (bit_cnt >= FIRST_DATA)) begin
                        rx <= {sdi, rx[DATA_WIDTH-1:1]};
                    end
                    if (bit_cnt == LAST_BIT) begin
                        state     <= S_GAP;
                        bit_cnt   <= '0;
                        gap_cnt   <= '0;
                        sdo       <= 1'b0;
                        wr_en     <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (!is_write) begin
                            rsp_rdata <= {sdi, rx[DATA_WIDTH-1:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        sdo     <= tx[0];
                        tx      <= tx >> 1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_piso_master.sv
// Directed bench for sipo_piso_master with a behavioural sipo_piso slave model.
module tb_sipo_piso_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, busy, strobe, wr_en, sdo, sdi;
    logic [31:0] rsp_rdata;

    logic        g_req_valid, g_req_ready, g_req_write;
    logic [3:0]  g_req_addr;
    logic [31:0] g_req_wdata;
    logic        g_rsp_valid, g_busy, g_strobe, g_wr_en, g_sdo;
    logic [31:0] g_rsp_rdata;

    sipo_piso_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .strobe(strobe), .wr_en(wr_en), .sdo(sdo), .sdi(sdi)
    );

    sipo_piso_master #(.GAP_CYCLES(1)) dut_gap1 (
        .clk(clk), .rst(rst),
        .req_valid(g_req_valid), .req_ready(g_req_ready), .req_write(g_req_write),
        .req_addr(g_req_addr), .req_wdata(g_req_wdata),
        .rsp_valid(g_rsp_valid), .rsp_rdata(g_rsp_rdata), .busy(g_busy),
        .strobe(g_strobe), .wr_en(g_wr_en), .sdo(g_sdo), .sdi(1'b0)
    );

    // Behavioural slave: frame counter restarts on strobe, reads drive dout from k = 4.
    logic        pre_en;
    logic [3:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] s_mem [16];
    logic [35:0] s_sh;
    logic [5:0]  s_cnt;
    logic        s_act, s_wr, s_dout;
    logic [3:0]  s_addr;

    assign sdi = s_dout;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_act  <= 1'b0;
            s_dout <= 1'b0;
            s_cnt  <= '0;
        end else begin
            if (pre_en) s_mem[pre_addr] <= pre_data;
            if (strobe) begin
                s_act  <= 1'b1;
                s_wr   <= wr_en;
                s_cnt  <= '0;
                s_dout <= 1'b0;
            end else if (s_act) begin
                s_sh[s_cnt] <= sdo;
                if (!s_wr && s_cnt == 6'd3) begin
                    s_addr <= {sdo, s_sh[2:0]};
                    s_dout <= s_mem[{sdo, s_sh[2:0]}][0];
                end else if (!s_wr && s_cnt >= 6'd4 && s_cnt <= 6'd34) begin
                    s_dout <= s_mem[s_addr][5'(s_cnt - 6'd3)];
                end
                if (s_cnt == 6'd35) begin
                    s_act  <= 1'b0;
                    s_dout <= 1'b0;
                    if (s_wr) s_mem[{sdo, s_sh[34:32]}] <= s_sh[31:0];
                end else begin
                    s_cnt <= s_cnt + 6'd1;
                end
            end
        end
    end

    int checks = 0;
    int passed = 0;

    logic [63:0] tr_strobe, tr_wr, tr_sdo, tr_rsp, tr_busy, tr_ready;
    logic [31:0] cap_rdata;

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Issues one request from idle and records cycles 1..43 after acceptance.
    task automatic run_frame(input logic w, input logic [3:0] a, input logic [31:0] d);
        tr_strobe = '0; tr_wr = '0; tr_sdo = '0; tr_rsp = '0; tr_busy = '0; tr_ready = '0;
        cap_rdata = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
        for (int n = 1; n <= 43; n++) begin
            @(negedge clk);
            tr_strobe[n] = strobe; tr_wr[n] = wr_en; tr_sdo[n] = sdo;
            tr_rsp[n] = rsp_valid; tr_busy[n] = busy; tr_ready[n] = req_ready;
            if (n == 39) cap_rdata = rsp_rdata;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", strobe); else passed++;
        checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else passed++;
        checks++; if (sdo !== 1'b0) $display("FAIL reset_sdo got %b want 0", sdo); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); else passed++;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_frame;
        logic [35:0] frame;
        logic [63:0] e_sdo, e_wr, e_busy;
        frame = {4'h0, 32'hD2F8B804};
        e_sdo = '0; e_wr = '0; e_busy = '0;
        for (int k = 0; k < 36; k++) e_sdo[3+k] = frame[k];
        for (int n = 1; n <= 38; n++) e_wr[n] = 1'b1;
        for (int n = 1; n <= 42; n++) e_busy[n] = 1'b1;
        run_frame(1'b1, 4'h0, 32'hD2F8B804);
        checks++; if (tr_sdo !== e_sdo) $display("FAIL wr_sdo got %h want %h", tr_sdo, e_sdo); else passed++;
        checks++; if (tr_wr !== e_wr) $display("FAIL wr_wr_en got %h want %h", tr_wr, e_wr); else passed++;
        checks++; if (tr_strobe !== 64'h4) $display("FAIL wr_strobe got %h want %h", tr_strobe, 64'h4); else passed++;
        checks++; if (tr_rsp !== (64'h1 << 39)) $display("FAIL wr_rsp_valid got %h want %h", tr_rsp, 64'h1 << 39); else passed++;
        checks++; if (tr_busy !== e_busy) $display("FAIL wr_busy got %h want %h", tr_busy, e_busy); else passed++;
        checks++; if (tr_ready !== (64'h1 << 43)) $display("FAIL wr_ready got %h want %h", tr_ready, 64'h1 << 43); else passed++;
        checks++; if (s_mem[0] !== 32'hD2F8B804) $display("FAIL wr_slave_mem got %h want d2f8b804", s_mem[0]); else passed++;
    endtask

    task automatic test_read_frame;
        logic [63:0] e_sdo;
        e_sdo = '0;
        e_sdo[3] = 1'b1; e_sdo[4] = 1'b1;
        preload(4'h3, 32'h722CD01A);
        run_frame(1'b0, 4'h3, 32'hFFFFFFFF);
        checks++; if (tr_sdo !== e_sdo) $display("FAIL rd_sdo got %h want %h", tr_sdo, e_sdo); else passed++;
        checks++; if (tr_wr !== 64'h0) $display("FAIL rd_wr_en got %h want 0", tr_wr); else passed++;
        checks++; if (tr_strobe !== 64'h4) $display("FAIL rd_strobe got %h want %h", tr_strobe, 64'h4); else passed++;
        checks++; if (tr_rsp !== (64'h1 << 39)) $display("FAIL rd_rsp_valid got %h want %h", tr_rsp, 64'h1 << 39); else passed++;
        checks++; if (cap_rdata !== 32'h722CD01A) $display("FAIL rd_rdata got %h want 722cd01a", cap_rdata); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (rsp_rdata !== 32'h722CD01A) $display("FAIL rd_rdata_hold got %h want 722cd01a", rsp_rdata); else passed++;
    endtask

    task automatic test_back_to_back;
        int first_ready;
        int extra_busy;
        logic [63:0] e_busy;
        first_ready = 0; extra_busy = 0;
        tr_busy = '0; tr_strobe = '0; tr_ready = '0; e_busy = '0;
        for (int n = 1; n <= 42; n++) e_busy[n] = 1'b1;
        preload(4'hC, 32'h13572468);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'hA; req_wdata = 32'h0F1E2D3C;
        @(posedge clk);
        #1;
        req_addr = 4'hB; req_wdata = 32'h4B5A6978;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            tr_busy[n] = busy;
            if (req_ready) begin
                first_ready = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (first_ready != 43) $display("FAIL b2b_accept_gap got %0d want 43", first_ready); else passed++;
        checks++; if (tr_busy !== e_busy) $display("FAIL b2b_busy got %h want %h", tr_busy, e_busy); else passed++;
        for (int n = 1; n <= 43; n++) begin
            @(negedge clk);
            tr_strobe[n] = strobe; tr_ready[n] = req_ready;
            if (n == 10) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 4'hC; req_wdata = 32'hDEADBEEF;
            end
            if (n == 11) req_valid = 1'b0;
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) extra_busy++;
        end
        checks++; if (tr_strobe !== 64'h4) $display("FAIL b2b_strobe got %h want %h", tr_strobe, 64'h4); else passed++;
        checks++; if (tr_ready !== (64'h1 << 43)) $display("FAIL b2b_ready got %h want %h", tr_ready, 64'h1 << 43); else passed++;
        checks++; if (extra_busy != 0) $display("FAIL b2b_ignored_pulse busy_cycles %0d want 0", extra_busy); else passed++;
        checks++; if (s_mem[4'hA] !== 32'h0F1E2D3C) $display("FAIL b2b_mem_a got %h want 0f1e2d3c", s_mem[4'hA]); else passed++;
        checks++; if (s_mem[4'hB] !== 32'h4B5A6978) $display("FAIL b2b_mem_b got %h want 4b5a6978", s_mem[4'hB]); else passed++;
        checks++; if (s_mem[4'hC] !== 32'h13572468) $display("FAIL b2b_mem_c got %h want 13572468", s_mem[4'hC]); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        int stray_rsp;
        stray_rsp = 0;
        preload(4'h5, 32'h5A5AC3C3);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h5; req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (23) @(negedge clk);
        checks++; if ({busy, wr_en} !== 2'b11) $display("FAIL rstmid_inflight got %b want 11", {busy, wr_en}); else passed++;
        rst = 1'b0;
        #1;
        checks++; if ({strobe, wr_en, sdo, rsp_valid, busy} !== 5'b0) $display("FAIL rstmid_outputs got %b want 00000", {strobe, wr_en, sdo, rsp_valid, busy}); else passed++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL rstmid_rdata got %h want 0", rsp_rdata); else passed++;
        checks++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", req_ready); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (rsp_valid) stray_rsp++;
        end
        checks++; if (stray_rsp != 0) $display("FAIL rstmid_no_rsp got %0d pulses want 0", stray_rsp); else passed++;
        run_frame(1'b0, 4'h5, 32'h0);
        checks++; if (cap_rdata !== 32'h5A5AC3C3) $display("FAIL rstmid_read5 got %h want 5a5ac3c3", cap_rdata); else passed++;
        checks++; if (tr_rsp !== (64'h1 << 39)) $display("FAIL rstmid_rsp got %h want %h", tr_rsp, 64'h1 << 39); else passed++;
    endtask

    task automatic test_loopback;
        logic [31:0] vals [10];
        vals[0] = 32'hD2F8B804; vals[1] = 32'h217500CC; vals[2] = 32'h8839E68F;
        vals[3] = 32'h722CD01A; vals[4] = 32'hC0B8ED5D; vals[5] = 32'hF6F73141;
        vals[6] = 32'hC45AC632; vals[7] = 32'hB1ACE73A;
        vals[8] = $urandom; vals[9] = $urandom;
        for (int i = 0; i < 10; i++) run_frame(1'b1, 4'(i), vals[i]);
        for (int i = 0; i < 10; i++) begin
            run_frame(1'b0, 4'(i), 32'h0);
            checks++;
            if (cap_rdata !== vals[i] || tr_rsp[39] !== 1'b1)
                $display("FAIL loop_read%0d got %h rsp %b want %h rsp 1", i, cap_rdata, tr_rsp[39], vals[i]);
            else passed++;
        end
    endtask

    task automatic test_gap_param;
        int ready_n, rsp_n;
        ready_n = 0; rsp_n = 0;
        @(negedge clk);
        g_req_valid = 1'b1; g_req_write = 1'b1; g_req_addr = 4'h1; g_req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        g_req_valid = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (g_rsp_valid && rsp_n == 0) rsp_n = n;
            if (g_req_ready) begin
                ready_n = n;
                break;
            end
        end
        checks++; if (ready_n != 40) $display("FAIL gap1_ready got %0d want 40", ready_n); else passed++;
        checks++; if (rsp_n != 39) $display("FAIL gap1_rsp got %0d want 39", rsp_n); else passed++;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        g_req_valid = 1'b0; g_req_write = 1'b0; g_req_addr = '0; g_req_wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        test_reset();
        test_write_frame();
        test_read_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        test_gap_param();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
